// File: rtl/array_div_pkg.sv
// Shared parameters, types and the long-division step for the multi-lane fixed-point divider.
package array_div_pkg;

  localparam int LANES     = 6;
  localparam int WIDTH     = 32;
  localparam int FRAC      = 11;
  localparam int QBITS_STG = 6;
  localparam int DSTG      = (WIDTH + FRAC + QBITS_STG - 1) / QBITS_STG;
  localparam int LAT       = DSTG + 2;
  localparam int NBITS     = DSTG * QBITS_STG;
  localparam int MW        = WIDTH + 1;

  typedef logic signed [WIDTH-1:0] fixed_t;
  typedef fixed_t [LANES-1:0]      fixed_vec_t;

  localparam fixed_t QMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam fixed_t QMIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [MW-1:0]    rem;
    logic [NBITS-1:0] num;
    logic [NBITS-1:0] quo;
    logic [MW-1:0]    den;
    logic             neg;
    logic             asgn;
    logic             azero;
    logic             dz;
  } div_stage_t;

  typedef struct packed {
    logic [WIDTH-1:0] lo;
    logic             sat;
    logic             neg;
    logic             asgn;
    logic             azero;
    logic             dz;
  } div_fin_t;

  // Resolves QBITS_STG quotient bits; a zero divisor yields zero bits so an
  // all-zero (reset) stage stays zero all the way to the output.
  function automatic div_stage_t div_step(input div_stage_t s);
    div_stage_t  t;
    logic [MW:0] sh;
    t = s;
    for (int i = 0; i < QBITS_STG; i++) begin
      sh    = {t.rem, t.num[NBITS-1]};
      t.num = t.num << 1;
      if ((t.den != '0) && (sh >= {1'b0, t.den})) begin
        sh    = sh - {1'b0, t.den};
        t.quo = {t.quo[NBITS-2:0], 1'b1};
      end else begin
        t.quo = {t.quo[NBITS-2:0], 1'b0};
      end
      t.rem = sh[MW-1:0];
    end
    return t;
  endfunction

endpackage

// File: rtl/array_div_lane.sv
// One divider lane: abs/flag capture, DSTG restoring-division stages, sign/saturate/zero output.
// Define ARRAY_DIV_SAT_EN to clamp out-of-range quotients; otherwise they wrap.
module array_div_lane
  import array_div_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_en,
  input  fixed_t i_dividend,
  input  fixed_t i_divisor,
  output fixed_t o_quotient
);

  logic [MW-1:0]          w_aext, w_dext, w_amag, w_dmag;
  div_stage_t             w_s0;
  div_stage_t [DSTG-1:0]  r_stg;
  div_fin_t               w_fin, r_fin;
  fixed_t                 w_q, r_q;

  // Last division stage folds straight into the compact output record.
  function automatic div_fin_t div_last(input div_stage_t s);
    div_stage_t t;
    div_fin_t   f;
    t       = div_step(s);
    f.lo    = t.quo[WIDTH-1:0];
    f.neg   = t.neg;
    f.asgn  = t.asgn;
    f.azero = t.azero;
    f.dz    = t.dz;
`ifdef ARRAY_DIV_SAT_EN
    f.sat   = t.neg ? (t.quo > {{(NBITS-WIDTH){1'b0}}, QMIN})
                    : (t.quo > {{(NBITS-WIDTH){1'b0}}, QMAX});
`else
    f.sat   = 1'b0;
`endif
    return f;
  endfunction

  always_comb begin
    w_aext     = {i_dividend[WIDTH-1], i_dividend};
    w_dext     = {i_divisor[WIDTH-1], i_divisor};
    w_amag     = i_dividend[WIDTH-1] ? (~w_aext + MW'(1)) : w_aext;
    w_dmag     = i_divisor[WIDTH-1]  ? (~w_dext + MW'(1)) : w_dext;
    w_s0       = '0;
    w_s0.num   = NBITS'({w_amag, {FRAC{1'b0}}});
    w_s0.den   = w_dmag;
    w_s0.neg   = i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
    w_s0.asgn  = i_dividend[WIDTH-1];
    w_s0.azero = (i_dividend == '0);
    w_s0.dz    = (i_divisor == '0);
  end

  assign w_fin = div_last(r_stg[DSTG-1]);

  always_comb begin
    w_q = r_fin.neg ? fixed_t'(~r_fin.lo + WIDTH'(1)) : fixed_t'(r_fin.lo);
    if (r_fin.dz)
      w_q = r_fin.azero ? '0 : (r_fin.asgn ? QMIN : QMAX);
    else if (r_fin.sat)
      w_q = r_fin.neg ? QMIN : QMAX;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stg <= '0;
      r_fin <= '0;
      r_q   <= '0;
    end else if (i_en) begin
      r_stg[0] <= w_s0;
      for (int k = 1; k < DSTG; k++)
        r_stg[k] <= div_step(r_stg[k-1]);
      r_fin <= w_fin;
      r_q   <= w_q;
    end
  end

  assign o_quotient = r_q;

endmodule

// File: rtl/array_div_unit.sv
// Shared multi-lane signed fixed-point divider: LANES dividends over one common divisor.
// Saturation on overflow is enabled by defining ARRAY_DIV_SAT_EN.
module array_div_unit
  import array_div_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  fixed_vec_t dividends,
  input  fixed_t     divisor,
  output fixed_vec_t quotients
);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    array_div_lane u_lane (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_en       (en),
      .i_dividend (dividends[l]),
      .i_divisor  (divisor),
      .o_quotient (quotients[l])
    );
  end

endmodule

// File: tb/tb_array_div_unit.sv
// Directed self-checking bench for array_div_unit (both ARRAY_DIV_SAT_EN builds).
module tb_array_div_unit;
  import array_div_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       en;
  fixed_vec_t dividends;
  fixed_t     divisor;
  fixed_vec_t quotients;

  int n_chk  = 0;
  int n_fail = 0;
  int vd[LANES];
  int ve[LANES];
  int cap[128];
  int cnt;

  array_div_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .dividends (dividends),
    .divisor   (divisor),
    .quotients (quotients)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold vd/dv for LAT enabled edges, then compare every lane with ve.
  task automatic run_vec(input string nm, input int dv);
    for (int l = 0; l < LANES; l++) dividends[l] = vd[l];
    divisor = dv;
    en      = 1'b1;
    repeat (LAT) step();
    for (int l = 0; l < LANES; l++)
      chk($sformatf("%s_l%0d", nm, l), quotients[l], ve[l]);
  endtask

  task automatic pulse_reset(input string nm);
    rst_n = 1'b0;
    #1;
    for (int l = 0; l < LANES; l++)
      chk($sformatf("%s_l%0d", nm, l), quotients[l], 32'd0);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    dividends = '0;
    divisor   = '0;
    #2;
    chk("rst_l0", quotients[0], 32'd0);
    chk("rst_l5", quotients[5], 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Basic and exact latency: nothing at LAT-1 edges, result at LAT.
    for (int l = 0; l < LANES; l++) dividends[l] = 6144;
    divisor = 2048;
    en      = 1'b1;
    repeat (LAT-1) step();
    chk("lat_early", quotients[0], 32'd0);
    step();
    for (int l = 0; l < LANES; l++)
      chk($sformatf("basic_l%0d", l), quotients[l], 32'd6144);

    vd = '{-6144, 6144, -6144, -6144, 6144, 0};
    ve = '{-3072, 3072, -3072, -3072, 3072, 0};
    run_vec("sgn_pos", 4096);
    vd = '{-6144, 6144, -6144, 2048, -2048, 0};
    ve = '{3072, -3072, 3072, -1024, 1024, 0};
    run_vec("sgn_neg", -4096);

    vd = '{1, -1, 3, -3, 2048, -2048};
    ve = '{682, -682, 2048, -2048, 1398101, -1398101};
    run_vec("trunc", 3);

    vd = '{100, -100, 0, 32'h7FFFFFFF, 32'h80000000, 1};
    ve = '{32'h7FFFFFFF, 32'h80000000, 0, 32'h7FFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    run_vec("dz", 0);

    vd = '{32'h7FFFFFFF, 32'h80000000, -1, 5, 32'h00100000, -32'h00100000};
`ifdef ARRAY_DIV_SAT_EN
    ve = '{32'h7FFFFFFF, 32'h80000000, -2048, 10240, 32'h7FFFFFFF, 32'h80000000};
`else
    ve = '{32'hFFFFF800, 0, -2048, 10240, 32'h80000000, 32'h80000000};
`endif
    run_vec("ovf", 1);

    vd = '{32'h80000000, 32'h40000000, 32'hC0000000, 0, 32'h7FFFFFFF, 1};
    ve = '{2048, -1024, 1024, 0, -2047, 0};
    run_vec("minmag", 32'h80000000);

    // Streaming with en toggling, then a mid-stream reset that must flush everything.
    pulse_reset("rst_pre");
    cnt = 0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      for (int l = 0; l < LANES; l++) dividends[l] = (cyc + 1 + l) * 2048;
      divisor = 2048;
      en      = (cyc % 3) != 2;
      step();
      if (en) begin
        cnt++;
        cap[cnt] = cyc + 1;
      end
      chk($sformatf("strm%0d_l0", cyc), quotients[0], (cnt >= LAT) ? cap[cnt-LAT+1] * 2048 : 0);
      chk($sformatf("strm%0d_l5", cyc), quotients[5], (cnt >= LAT) ? (cap[cnt-LAT+1] + 5) * 2048 : 0);
      if (cyc == 20) begin
        pulse_reset("rst_mid");
        cnt = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
